// File: rtl/tdm_demux_4ch.sv
// -----------------------------------------------------------------------------
// tdm_demux_4ch
//   Receive side of a 4-slot time-division link. Beats arrive one WIDTH-bit word
//   at a time; slot 0 of each frame is marked with frame_sync. The block hunts
//   for the first sync, then collects slots 0..2 in shadow registers.
//
//   On the slot-3 beat it copies all four words into ch0..ch3 on the same edge,
//   so a downstream reader never sees a half-updated frame. Any sync
//   irregularity produces a sync_err pulse:
//     - a missing sync drops back to hunting;
//     - an early sync restarts the frame.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   din          slot data word
//   din_valid    din/frame_sync carry a beat this cycle
//   frame_sync   beat is slot 0 (ignored without din_valid)
//   ch0..ch3     last complete frame, slot k on chk
//   sel          one-hot of the slot the previous beat was stored as (0 if dropped)
//   frame_valid  one-cycle pulse when ch0..ch3 have just been refreshed
//   locked       receiver is aligned to the frame
//   sync_err     one-cycle pulse on an alignment violation
// -----------------------------------------------------------------------------
module tdm_demux_4ch #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             frame_sync,
   output logic [WIDTH-1:0] ch0,
   output logic [WIDTH-1:0] ch1,
   output logic [WIDTH-1:0] ch2,
   output logic [WIDTH-1:0] ch3,
   output logic [3:0]       sel,
   output logic             frame_valid,
   output logic             locked,
   output logic             sync_err
);

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       slot_q, slot_d;
   logic [WIDTH-1:0] shadow0_q, shadow0_d;
   logic [WIDTH-1:0] shadow1_q, shadow1_d;
   logic [WIDTH-1:0] shadow2_q, shadow2_d;
   logic [WIDTH-1:0] ch0_q, ch0_d;
   logic [WIDTH-1:0] ch1_q, ch1_d;
   logic [WIDTH-1:0] ch2_q, ch2_d;
   logic [WIDTH-1:0] ch3_q, ch3_d;
   logic [3:0]       sel_q, sel_d;
   logic             frame_valid_q, frame_valid_d;
   logic             sync_err_q, sync_err_d;

   // Register bank; every output comes straight from a flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= HUNT;
         slot_q        <= 2'd0;
         shadow0_q     <= '0;
         shadow1_q     <= '0;
         shadow2_q     <= '0;
         ch0_q         <= '0;
         ch1_q         <= '0;
         ch2_q         <= '0;
         ch3_q         <= '0;
         sel_q         <= 4'b0000;
         frame_valid_q <= 1'b0;
         sync_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         slot_q        <= slot_d;
         shadow0_q     <= shadow0_d;
         shadow1_q     <= shadow1_d;
         shadow2_q     <= shadow2_d;
         ch0_q         <= ch0_d;
         ch1_q         <= ch1_d;
         ch2_q         <= ch2_d;
         ch3_q         <= ch3_d;
         sel_q         <= sel_d;
         frame_valid_q <= frame_valid_d;
         sync_err_q    <= sync_err_d;
      end
   end

   // Next-state logic. Pulses (sel, frame_valid, sync_err) default to 0, so
   // cycles without a beat clear them while everything else holds.
   always_comb begin
      state_d       = state_q;
      slot_d        = slot_q;
      shadow0_d     = shadow0_q;
      shadow1_d     = shadow1_q;
      shadow2_d     = shadow2_q;
      ch0_d         = ch0_q;
      ch1_d         = ch1_q;
      ch2_d         = ch2_q;
      ch3_d         = ch3_q;
      sel_d         = 4'b0000;
      frame_valid_d = 1'b0;
      sync_err_d    = 1'b0;

      if (din_valid) begin
         unique case (state_q)
            HUNT: begin
               // Beats without sync are silently discarded while hunting.
               if (frame_sync) begin
                  shadow0_d = din;
                  slot_d    = 2'd1;
                  state_d   = LOCKED;
                  sel_d     = 4'b0001;
               end
            end

            LOCKED: begin
               if (frame_sync) begin
                  // Sync is always taken as a fresh slot 0. Arriving mid-frame it
                  // abandons the partial frame and reports the misalignment.
                  sync_err_d = (slot_q != 2'd0);
                  shadow0_d  = din;
                  slot_d     = 2'd1;
                  sel_d      = 4'b0001;
               end else if (slot_q == 2'd0) begin
                  // Expected a sync here: alignment lost, start hunting again.
                  sync_err_d = 1'b1;
                  state_d    = HUNT;
                  slot_d     = 2'd0;
               end else begin
                  unique case (slot_q)
                     2'd1: begin
                        shadow1_d = din;
                        slot_d    = 2'd2;
                        sel_d     = 4'b0010;
                     end
                     2'd2: begin
                        shadow2_d = din;
                        slot_d    = 2'd3;
                        sel_d     = 4'b0100;
                     end
                     default: begin
                        // Last slot: publish the whole frame on one edge.
                        ch0_d         = shadow0_q;
                        ch1_d         = shadow1_q;
                        ch2_d         = shadow2_q;
                        ch3_d         = din;
                        slot_d        = 2'd0;
                        sel_d         = 4'b1000;
                        frame_valid_d = 1'b1;
                     end
                  endcase
               end
            end

            default: begin
               state_d = HUNT;
               slot_d  = 2'd0;
            end
         endcase
      end
   end

   assign ch0         = ch0_q;
   assign ch1         = ch1_q;
   assign ch2         = ch2_q;
   assign ch3         = ch3_q;
   assign sel         = sel_q;
   assign frame_valid = frame_valid_q;
   assign sync_err    = sync_err_q;
   assign locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux_4ch
//   Self-checking bench for tdm_demux_4ch. It runs in four parts:
//     - a hand-written vector table covering lock acquisition, early sync,
//       missing sync and relock;
//     - a gapped-frame sequence;
//     - an asynchronous mid-stream reset;
//     - randomized beats compared against a queue-style reference model.
// -----------------------------------------------------------------------------
module tb_tdm_demux_4ch;

   logic       clk;
   logic       rst_n;
   logic [3:0] din;
   logic       din_valid;
   logic       frame_sync;
   logic [3:0] ch0, ch1, ch2, ch3;
   logic [3:0] sel;
   logic       frame_valid;
   logic       locked;
   logic       sync_err;

   int checks = 0;
   int errors = 0;

   tdm_demux_4ch #(.WIDTH(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .din         (din),
      .din_valid   (din_valid),
      .frame_sync  (frame_sync),
      .ch0         (ch0),
      .ch1         (ch1),
      .ch2         (ch2),
      .ch3         (ch3),
      .sel         (sel),
      .frame_valid (frame_valid),
      .locked      (locked),
      .sync_err    (sync_err)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic        fs;
      logic [3:0]  d;
      logic [15:0] ch;
      logic [3:0]  sel;
      logic        fv;
      logic        lk;
      logic        se;
   } vec_t;

   vec_t tbl[20];

   // Reference model state: aligned flag, words gathered so far, last frame.
   bit       mLocked;
   int       mCount;
   bit [3:0] mWords[4];
   bit [3:0] mCh[4];

   // Compares one observed value against its expected value and logs any failure.
   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Drives one cycle of inputs, then samples 1 ns after the following rising edge.
   task automatic applyStimulus(input logic v, input logic fs, input logic [3:0] d);
      din_valid  = v;
      frame_sync = fs;
      din        = d;
      @(posedge clk);
      #1;
   endtask

   // Applies reset for a couple of cycles and releases it away from a clock edge.
   task automatic doReset();
      din_valid  = 1'b0;
      frame_sync = 1'b0;
      din        = 4'h0;
      rst_n      = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      mLocked = 0;
      mCount  = 0;
      for (int i = 0; i < 4; i++) begin
         mWords[i] = '0;
         mCh[i]    = '0;
      end
   endtask

   // Checks every output against the given expected values.
   task automatic checkAll(input string tag, input logic [15:0] eCh, input logic [3:0] eSel,
                           input logic eFv, input logic eLk, input logic eSe);
      checkOutput({tag, ".ch"},  {ch3, ch2, ch1, ch0}, eCh);
      checkOutput({tag, ".sel"}, {12'h0, sel}, {12'h0, eSel});
      checkOutput({tag, ".fv"},  {15'h0, frame_valid}, {15'h0, eFv});
      checkOutput({tag, ".lk"},  {15'h0, locked}, {15'h0, eLk});
      checkOutput({tag, ".se"},  {15'h0, sync_err}, {15'h0, eSe});
   endtask

   initial begin
      bit [3:0]    vals[4];
      int          fvCount;
      int          gap;
      logic        rv, rfs;
      logic [3:0]  rd;
      logic [3:0]  eSel;
      logic        eFv, eSe;

      //                v   fs  d      ch        sel     fv  lk  se
      tbl[0]  = '{1'b1, 1'b0, 4'h1, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 4'h2, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 4'h5, 16'h0000, 4'b0001, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 4'hF, 16'h0000, 4'b0000, 1'b0, 1'b1, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 4'h6, 16'h0000, 4'b0010, 1'b0, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 4'h7, 16'h0000, 4'b0100, 1'b0, 1'b1, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 4'h8, 16'h8765, 4'b1000, 1'b1, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 4'h0, 16'h8765, 4'b0000, 1'b0, 1'b1, 1'b0};
      tbl[8]  = '{1'b1, 1'b1, 4'h3, 16'h8765, 4'b0001, 1'b0, 1'b1, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 4'h4, 16'h8765, 4'b0010, 1'b0, 1'b1, 1'b0};
      tbl[10] = '{1'b1, 1'b1, 4'h9, 16'h8765, 4'b0001, 1'b0, 1'b1, 1'b1};
      tbl[11] = '{1'b1, 1'b0, 4'hA, 16'h8765, 4'b0010, 1'b0, 1'b1, 1'b0};
      tbl[12] = '{1'b1, 1'b0, 4'hB, 16'h8765, 4'b0100, 1'b0, 1'b1, 1'b0};
      tbl[13] = '{1'b1, 1'b0, 4'hC, 16'hCBA9, 4'b1000, 1'b1, 1'b1, 1'b0};
      tbl[14] = '{1'b1, 1'b0, 4'hE, 16'hCBA9, 4'b0000, 1'b0, 1'b0, 1'b1};
      tbl[15] = '{1'b1, 1'b1, 4'hA, 16'hCBA9, 4'b0001, 1'b0, 1'b1, 1'b0};
      tbl[16] = '{1'b1, 1'b0, 4'hB, 16'hCBA9, 4'b0010, 1'b0, 1'b1, 1'b0};
      tbl[17] = '{1'b1, 1'b0, 4'hC, 16'hCBA9, 4'b0100, 1'b0, 1'b1, 1'b0};
      tbl[18] = '{1'b1, 1'b0, 4'hD, 16'hDCBA, 4'b1000, 1'b1, 1'b1, 1'b0};
      tbl[19] = '{1'b0, 1'b0, 4'h0, 16'hDCBA, 4'b0000, 1'b0, 1'b1, 1'b0};

      doReset();
      checkAll("reset", 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0);

      // Table-driven vectors.
      for (int i = 0; i < 20; i++) begin
         applyStimulus(tbl[i].v, tbl[i].fs, tbl[i].d);
         checkAll($sformatf("vec%0d", i), tbl[i].ch, tbl[i].sel, tbl[i].fv, tbl[i].lk, tbl[i].se);
      end

      // Frame with idle gaps between beats: one frame_valid, sel quiet in gaps.
      doReset();
      vals = '{4'hA, 4'hB, 4'hC, 4'hD};
      fvCount = 0;
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, k == 0, vals[k]);
         checkOutput($sformatf("gap.sel%0d", k), {12'h0, sel}, 16'h1 << k);
         fvCount += int'(frame_valid);
         gap = $urandom_range(1, 3);
         for (int g = 0; g < gap; g++) begin
            applyStimulus(1'b0, 1'b1, 4'hF);
            checkOutput("gap.idlesel", {12'h0, sel}, 16'h0);
            fvCount += int'(frame_valid);
         end
      end
      checkOutput("gap.fvcount", fvCount[15:0], 16'd1);
      checkOutput("gap.ch", {ch3, ch2, ch1, ch0}, 16'hDCBA);

      // Asynchronous reset mid-frame with a pending sel pulse: outputs clear before any edge.
      applyStimulus(1'b1, 1'b1, 4'h7);
      #3 rst_n = 1'b0;
      #1;
      checkAll("asyncrst", 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b1;
      din_valid = 1'b0;
      @(posedge clk);
      #1;
      mLocked = 0;
      mCount  = 0;
      for (int i = 0; i < 4; i++) begin
         mWords[i] = '0;
         mCh[i]    = '0;
      end

      // Randomized beats against the reference model.
      for (int n = 0; n < 800; n++) begin
         rv = ($urandom_range(0, 3) != 0);
         rd = 4'($urandom_range(0, 15));
         if (mLocked && mCount == 0)
            rfs = ($urandom_range(0, 9) != 0);
         else if (mLocked)
            rfs = ($urandom_range(0, 9) == 0);
         else
            rfs = ($urandom_range(0, 2) == 0);

         eSel = 4'b0000;
         eFv  = 1'b0;
         eSe  = 1'b0;
         if (rv) begin
            if (!mLocked) begin
               if (rfs) begin
                  mLocked   = 1;
                  mWords[0] = rd;
                  mCount    = 1;
                  eSel      = 4'b0001;
               end
            end else if (rfs) begin
               if (mCount != 0) eSe = 1'b1;
               mWords[0] = rd;
               mCount    = 1;
               eSel      = 4'b0001;
            end else if (mCount == 0) begin
               eSe     = 1'b1;
               mLocked = 0;
            end else begin
               mWords[mCount] = rd;
               eSel           = 4'b0001 << mCount;
               mCount++;
               if (mCount == 4) begin
                  mCh    = mWords;
                  eFv    = 1'b1;
                  mCount = 0;
               end
            end
         end

         applyStimulus(rv, rfs, rd);
         checkAll($sformatf("rnd%0d", n), {mCh[3], mCh[2], mCh[1], mCh[0]}, eSel, eFv,
                  mLocked, eSe);
         checkOutput("rnd.exclusive", {15'h0, frame_valid & sync_err}, 16'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
